// File: rtl/board_uart_tx_pkg.sv
// rtl/board_uart_tx_pkg.sv - shared constants, state type and hex encoder for the board reporter
package board_uart_tx_pkg;

    localparam int FRAME_BYTES = 24;
    localparam int ROW_BYTES   = 6;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_e;

    // One tile exponent to its uppercase ASCII hex digit
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/board_uart_tx_uart_tx_byte.sv
// rtl/board_uart_tx_uart_tx_byte.sv - 8N1 byte serializer with valid/ready handshake
module uart_tx_byte #(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       done_o
);

    logic        active_q, active_d;
    logic [15:0] baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic [8:0]  shift_q, shift_d;
    logic        tx_q, tx_d;

    logic bit_end;
    logic last_bit_end;

    assign bit_end      = active_q && (baud_q == 16'(BAUD_DIV - 1));
    assign last_bit_end = bit_end && (bit_q == 4'd9);

    // Ready also in the stop bit's final cycle so bytes follow back to back
    assign ready_o = !active_q || last_bit_end;
    assign done_o  = last_bit_end;
    assign tx_o    = tx_q;

    // Bit timing and shifting; an accepted byte overrides the stop-bit wrap-up
    always_comb begin
        active_d = active_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        if (active_q) begin
            if (bit_end) begin
                baud_d = 16'd0;
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[8:1]};
                end
            end else begin
                baud_d = baud_q + 16'd1;
            end
        end
        if (valid_i && ready_o) begin
            active_d = 1'b1;
            baud_d   = 16'd0;
            bit_d    = 4'd0;
            tx_d     = 1'b0;
            shift_d  = {1'b1, data_i};
        end
    end

    // Serializer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            baud_q   <= 16'd0;
            bit_q    <= 4'd0;
            shift_q  <= 9'h1FF;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/board_uart_tx.sv
// rtl/board_uart_tx.sv - sends the 2048 board as four hex text rows over UART on change or request
module board_uart_tx
    import board_uart_tx_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] board,
    input  logic        send,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [1:0] LAST_ROW = 2'(FRAME_BYTES / ROW_BYTES - 1);
    localparam logic [2:0] LAST_COL = 3'(ROW_BYTES - 1);

    state_e      state_q, state_d;
    logic [63:0] last_q, last_d;
    logic [63:0] snap_q, snap_d;
    logic        pending_q, pending_d;
    logic [1:0]  row_q, row_d;
    logic [2:0]  col_q, col_d;
    logic        issued_q, issued_d;
    logic        done_q, done_d;

    logic        byte_valid;
    logic        byte_ready;
    logic        byte_done;
    logic [7:0]  byte_data;
    logic [5:0]  nib_lsb;
    logic [3:0]  nib;

    // Byte select: columns 0..3 are tile digits, 4 and 5 terminate the row
    assign nib_lsb   = 6'd60 - {row_q, col_q[1:0], 2'b00};
    assign nib       = snap_q[nib_lsb +: 4];
    assign byte_data = (col_q == 3'd4) ? CR :
                       (col_q == 3'd5) ? LF : hex_ascii(nib);

    assign byte_valid = (state_q == ST_SEND) && !issued_q;
    assign busy       = (state_q == ST_SEND);
    assign frame_done = done_q;

    uart_tx_byte #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte (
        .clk    (clk),
        .rst    (rst),
        .valid_i(byte_valid),
        .data_i (byte_data),
        .ready_o(byte_ready),
        .tx_o   (tx),
        .done_o (byte_done)
    );

    // Trigger detection, snapshot capture, byte sequencing and frame end
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        snap_d    = snap_q;
        pending_d = pending_q;
        row_d     = row_q;
        col_d     = col_q;
        issued_d  = issued_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((board != last_q) || send || pending_q) begin
                    snap_d    = board;
                    last_d    = board;
                    pending_d = 1'b0;
                    row_d     = 2'd0;
                    col_d     = 3'd0;
                    issued_d  = 1'b0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (send) begin
                    pending_d = 1'b1;
                end
                if (byte_valid && byte_ready) begin
                    if (col_q == LAST_COL) begin
                        col_d = 3'd0;
                        if (row_q == LAST_ROW) begin
                            issued_d = 1'b1;
                        end else begin
                            row_d = row_q + 2'd1;
                        end
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
                if (issued_q && byte_done) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_q    <= 64'd0;
            snap_q    <= 64'd0;
            pending_q <= 1'b0;
            row_q     <= 2'd0;
            col_q     <= 3'd0;
            issued_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            snap_q    <= snap_d;
            pending_q <= pending_d;
            row_q     <= row_d;
            col_q     <= col_d;
            issued_q  <= issued_d;
            done_q    <= done_d;
        end
    end

endmodule
